// File: rtl/act_pkg.sv
// Shared constants and types for the activation SRAM writers.
// Word geometry: 3 channels x 9 activations (3x3 tile) x 10 bits.
package act_pkg;
    localparam int CH_NUM       = 3;
    localparam int ACT_PER_ADDR = 9;
    localparam int BW_PER_ACT   = 10;

    localparam int WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int MASK_W = CH_NUM * ACT_PER_ADDR;
    localparam int ADDR_W = 9;
    localparam int PIX_W  = CH_NUM * BW_PER_ACT;

    localparam int DEF_IMG_W = 72;
    localparam int DEF_IMG_H = 60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } act_state_e;
endpackage

// File: rtl/act_row_packer.sv
// Places one tile row (three pixels) into a masked 270-bit activation word.
// Activation index for channel c, tile row r, tile column k is c*9 + r*3 + k.
module act_row_packer
    import act_pkg::*;
(
    input  logic [1:0]        sub_row,
    input  logic [PIX_W-1:0]  pix0,
    input  logic [PIX_W-1:0]  pix1,
    input  logic [PIX_W-1:0]  pix2,
    output logic [MASK_W-1:0] wordmask,
    output logic [WORD_W-1:0] wdata
);
    logic [PIX_W-1:0] pix [3];

    assign pix[0] = pix0;
    assign pix[1] = pix1;
    assign pix[2] = pix2;

    // Mask bit 1 keeps the old SRAM contents; only the selected tile row is written.
    for (genvar i = 0; i < MASK_W; i++) begin : g_act
        localparam int C = i / ACT_PER_ADDR;
        localparam int R = (i % ACT_PER_ADDR) / 3;
        localparam int K = i % 3;

        logic hit;

        assign hit         = (sub_row == 2'(R));
        assign wordmask[i] = ~hit;
        assign wdata[i*BW_PER_ACT +: BW_PER_ACT] =
            hit ? pix[K][C*BW_PER_ACT +: BW_PER_ACT] : '0;
    end
endmodule

// File: rtl/act_sram_loader.sv
// Raster-order pixel loader: packs 3x3 tiles into the activation SRAM,
// one masked write per completed tile row, one frame per start pulse.
module act_sram_loader
    import act_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [MASK_W-1:0] sram_wordmask,
    output logic [WORD_W-1:0] sram_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);
    localparam int BLK_W = IMG_W / 3;
    localparam int BLK_H = IMG_H / 3;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] LOAD  = ST_LOAD;
    localparam logic [1:0] FLUSH = ST_FLUSH;

    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BLK_W_A  = ADDR_W'(BLK_W);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(BLK_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(BLK_H - 1);

    logic [1:0]         state;
    logic [1:0]         sub_col;
    logic [1:0]         sub_row;
    logic [ADDR_W-1:0]  blk_col;
    logic [ADDR_W-1:0]  blk_row;
    logic [ADDR_W-1:0]  row_base;
    logic [2*PIX_W-1:0] stage;

    logic               accept;
    logic               col_wrap;
    logic               blk_col_wrap;
    logic               row_wrap;
    logic               last_pix;
    logic [MASK_W-1:0]  pk_mask;
    logic [WORD_W-1:0]  pk_data;

    // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
    // in_ready is high for the whole LOAD state and nothing ever stalls it.
    assign accept       = in_valid && in_ready;
    assign col_wrap     = (sub_col == 2'd2);
    assign blk_col_wrap = col_wrap && (blk_col == LAST_COL);
    assign row_wrap     = blk_col_wrap && (sub_row == 2'd2);
    assign last_pix     = row_wrap && (blk_row == LAST_ROW);
    assign fsm_state    = state;

    act_row_packer u_packer (
        .sub_row  (sub_row),
        .pix0     (stage[PIX_W-1:0]),
        .pix1     (stage[2*PIX_W-1:PIX_W]),
        .pix2     (in_data),
        .wordmask (pk_mask),
        .wdata    (pk_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sram_csb      <= 1'b1;
            sram_wsb      <= 1'b1;
            sram_waddr    <= '0;
            sram_wordmask <= '1;
            sram_wdata    <= '0;
            sub_col       <= 2'd0;
            sub_row       <= 2'd0;
            blk_col       <= '0;
            blk_row       <= '0;
            row_base      <= '0;
            stage         <= '0;
        end else begin
            sram_csb <= 1'b1;
            sram_wsb <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        sub_col  <= 2'd0;
                        sub_row  <= 2'd0;
                        blk_col  <= '0;
                        blk_row  <= '0;
                        row_base <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        sub_col <= col_wrap ? 2'd0 : sub_col + 2'd1;
                        if (sub_col == 2'd0) stage[PIX_W-1:0]       <= in_data;
                        if (sub_col == 2'd1) stage[2*PIX_W-1:PIX_W] <= in_data;
                        // Third pixel of a tile row: launch the coalesced write.
                        if (col_wrap) begin
                            blk_col       <= blk_col_wrap ? '0 : blk_col + ONE_A;
                            sram_csb      <= 1'b0;
                            sram_wsb      <= 1'b0;
                            sram_waddr    <= row_base + blk_col;
                            sram_wordmask <= pk_mask;
                            sram_wdata    <= pk_data;
                        end
                        if (blk_col_wrap) sub_row <= row_wrap ? 2'd0 : sub_row + 2'd1;
                        if (row_wrap) begin
                            blk_row  <= last_pix ? '0 : blk_row + ONE_A;
                            row_base <= last_pix ? '0 : row_base + BLK_W_A;
                        end
                        if (last_pix) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_act_sram_loader.sv
// Self-checking bench for act_sram_loader: directed table, full frames with
// an SRAM model against a golden tile image, restart and reset corner cases.
module tb_act_sram_loader;
    import act_pkg::*;

    localparam int IMG_W   = 72;
    localparam int IMG_H   = 60;
    localparam int BLK_W   = IMG_W / 3;
    localparam int N_WORDS = (IMG_W / 3) * (IMG_H / 3);
    localparam int N_PIX   = IMG_W * IMG_H;

    typedef struct {
        logic [PIX_W-1:0]  data;
        logic              exp_wr;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [PIX_W-1:0]  in_data = '0;
    logic              in_ready;
    logic              sram_csb;
    logic              sram_wsb;
    logic [ADDR_W-1:0] sram_waddr;
    logic [MASK_W-1:0] sram_wordmask;
    logic [WORD_W-1:0] sram_wdata;
    logic              busy;
    logic              done;
    logic [1:0]        fsm_state;

    act_sram_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sram_csb      (sram_csb),
        .sram_wsb      (sram_wsb),
        .sram_waddr    (sram_waddr),
        .sram_wordmask (sram_wordmask),
        .sram_wdata    (sram_wdata),
        .busy          (busy),
        .done          (done),
        .fsm_state     (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pixel image and the tile word it should produce at each address
    function automatic logic [PIX_W-1:0] pix(input int r, input int c);
        logic [9:0] c0, c1, c2;
        c0 = 10'((r * 31 + c * 17) % 1024);
        c1 = 10'((r * 13 + c + 1) % 1024);
        c2 = 10'((r * 7 + c * 3 + 5) % 1024);
        return {c2, c1, c0};
    endfunction

    function automatic logic [WORD_W-1:0] golden(input int a);
        logic [WORD_W-1:0] w;
        logic [PIX_W-1:0]  p;
        int br, bc;
        w  = '0;
        br = a / BLK_W;
        bc = a % BLK_W;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                p = pix(br * 3 + r, bc * 3 + k);
                for (int c = 0; c < 3; c++) w[(c * 9 + r * 3 + k) * 10 +: 10] = p[c * 10 +: 10];
            end
        end
        return w;
    endfunction

    function automatic logic [MASK_W-1:0] row_mask(input int r);
        logic [MASK_W-1:0] m;
        m = '1;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++) m[c * 9 + r * 3 + k] = 1'b0;
        return m;
    endfunction

    // Scoreboard: expected {sub_row, addr} per completed triple, SRAM model
    logic [10:0]       exp_q[$];
    logic [WORD_W-1:0] mem [N_WORDS];
    logic [WORD_W-1:0] mem_ref [N_WORDS];
    int                wr_cnt [N_WORDS];
    int                total_wr = 0;
    int                done_cnt = 0;
    int                exp_done = 0;
    int unsigned       done_cyc = 0;
    int unsigned       last_acc_cyc = 0;

    always @(negedge clk) begin : mon
        logic [10:0] e;
        if (rst_n) begin
            if (!sram_csb) begin
                check("wsb_with_csb", sram_wsb, 0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: write to addr %0d with no completed triple", sram_waddr);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", sram_waddr, e[8:0]);
                    check("write_mask", sram_wordmask, row_mask(int'(e[10:9])));
                end
                if (sram_waddr < N_WORDS) begin
                    for (int i = 0; i < MASK_W; i++)
                        if (!sram_wordmask[i]) mem[sram_waddr][i * 10 +: 10] = sram_wdata[i * 10 +: 10];
                    wr_cnt[sram_waddr]++;
                end
                total_wr++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Driver tasks
    task automatic send_pixel(input logic [PIX_W-1:0] d, input int gap, input int r, input int c, output bit ok);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        ok       = 1'b0;
        for (int t = 0; t < 20; t++) begin
            bit rdy;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: pixel (%0d,%0d) accepted=%0d required=1", r, c, ok);
        end else begin
            last_acc_cyc = cyc;
            if (c % 3 == 2) exp_q.push_back({2'(r % 3), 9'((r / 3) * BLK_W + c / 3)});
        end
    endtask

    task automatic run_frame(input int first_pix, input int stop_pix, input int idle_pct, input int start_pix);
        bit ok;
        for (int n = first_pix; n < N_PIX; n++) begin
            int r, c, gap;
            r   = n / IMG_W;
            c   = n % IMG_W;
            gap = 0;
            while (idle_pct > 0 && gap < 8 && $urandom_range(99) < idle_pct) gap++;
            start = (n == start_pix);
            send_pixel(pix(r, c), gap, r, c, ok);
            start = 1'b0;
            if (!ok || n == stop_pix) return;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_model();
        for (int a = 0; a < N_WORDS; a++) begin
            mem[a]    = '0;
            wr_cnt[a] = 0;
        end
        total_wr = 0;
    endtask

    // Called right after the final acceptance edge.
    task automatic frame_tail(input bit restart);
        exp_done++;
        if (restart) start = 1'b1;
        @(negedge clk);
        check("done_t1", done, 1);
        check("flush_state_t1", fsm_state, 2);
        check("last_write_t1", sram_csb, 0);
        check("busy_t1", busy, 1);
        check("ready_t1", in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_t2", done, 0);
        check("idle_state_t2", fsm_state, 0);
        check("ready_t2", in_ready, 0);
        check("busy_t2", busy, 0);
        check("done_cycle", done_cyc, last_acc_cyc);
        check("done_count", done_cnt, exp_done);
        check("queue_drained", exp_q.size(), 0);
        if (restart) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("restart_ready_t3", in_ready, 1);
            check("restart_state_t3", fsm_state, 1);
        end
    endtask

    task automatic check_frame_contents(input string name, input bit vs_golden);
        int bad_cnt, bad_mem;
        bad_cnt = 0;
        bad_mem = 0;
        for (int a = 0; a < N_WORDS; a++) begin
            if (wr_cnt[a] != 3) bad_cnt++;
            if (mem[a] !== (vs_golden ? golden(a) : mem_ref[a])) bad_mem++;
        end
        check({name, "_total_writes"}, total_wr, 1440);
        check({name, "_addr_not_3_writes"}, bad_cnt, 0);
        check({name, "_bad_words"}, bad_mem, 0);
    endtask

    initial begin : watchdog
        #800000;
        errors++;
        $display("FAIL watchdog: simulation time %0t exceeded the limit", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        vec_t              vecs[6];
        logic [WORD_W-1:0] rest;
        bit                ok;

        vecs[0] = '{30'h00100401, 1'b0, 9'd0};
        vecs[1] = '{30'h00200802, 1'b0, 9'd0};
        vecs[2] = '{30'h00300C03, 1'b1, 9'd0};
        vecs[3] = '{pix(0, 3), 1'b0, 9'd0};
        vecs[4] = '{pix(0, 4), 1'b0, 9'd0};
        vecs[5] = '{pix(0, 5), 1'b1, 9'd1};
        clear_model();

        // Reset with start held
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csb", sram_csb, 1);
        check("rst_wsb", sram_wsb, 1);
        check("rst_waddr", sram_waddr, 0);
        check("rst_mask", sram_wordmask, {MASK_W{1'b1}});
        check("rst_wdata", sram_wdata, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", fsm_state, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready_no_start", in_ready, 0);
        pulse_start();
        @(negedge clk);
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);

        // Directed table: first two tile rows of row 0
        for (int i = 0; i < 6; i++) begin
            send_pixel(vecs[i].data, 0, 0, i, ok);
            @(negedge clk);
            check("tbl_csb", sram_csb, !vecs[i].exp_wr);
            check("tbl_wsb", sram_wsb, !vecs[i].exp_wr);
            if (vecs[i].exp_wr) check("tbl_waddr", sram_waddr, vecs[i].exp_addr);
            if (i == 2) begin
                check("tbl_mask", sram_wordmask, 27'h7E3F1F8);
                check("tbl_wdata_ch0", sram_wdata[29:0], 30'h00300801);
                check("tbl_wdata_ch1", sram_wdata[119:90], 30'h00300801);
                check("tbl_wdata_ch2", sram_wdata[209:180], 30'h00300801);
                rest = sram_wdata;
                rest[29:0]    = '0;
                rest[119:90]  = '0;
                rest[209:180] = '0;
                check("tbl_wdata_rest", rest, 0);
            end
        end

        // Reset right after the triple that targets address 37 completes
        run_frame(6, 3 * IMG_W + 41, 0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_csb", sram_csb, 1);
        check("midrst_wsb", sram_wsb, 1);
        check("midrst_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state", fsm_state, 0);
        check("midrst_waddr", sram_waddr, 0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_write", sram_csb, 1);

        // Frame 1: continuous stream
        clear_model();
        pulse_start();
        run_frame(0, -1, 0, -1);
        frame_tail(1'b0);
        check_frame_contents("cont", 1'b1);
        for (int a = 0; a < N_WORDS; a++) mem_ref[a] = mem[a];

        // Frame 2: ~40% idle gaps, stray start during LOAD, start in done cycle
        clear_model();
        pulse_start();
        run_frame(0, -1, 40, 100);
        frame_tail(1'b1);
        check_frame_contents("gaps", 1'b0);

        // Frame 3: started two cycles after done
        clear_model();
        run_frame(0, -1, 0, -1);
        frame_tail(1'b0);
        check_frame_contents("restart", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
